// File: rtl/nonce_dispatch_ctrl.sv
// nonce_dispatch_ctrl
//   Sequences a bank of NUM_CORES SHA-256 nonce cores for one hashing job.
//   On start it hands out nonces 0..NUM_NONCES-1 to idle cores, collects each
//   core's H0 word, and stores it through the single memory write port at
//   output_addr + nonce. Results are written in completion order.
//
// Ports
//   clk, reset_n        clock (rising edge) / asynchronous active-low reset
//   start, output_addr  job request (sampled only in IDLE) and result base address
//   done                one-cycle pulse after all results are written
//   core_start          one-hot launch pulse; core_nonce is valid in the same cycle
//   core_done/core_hash per-core result ready (held until acked) and H0 word
//   core_ack            one-hot result accept, coincident with the memory write
//   mem_clk, mem_we, mem_addr, mem_write_data   memory write port (mem_clk = clk)
//   dbg_state           current FSM state (0 IDLE, 1 RUN, 2 FIN)
//
// Handshake: a core owns its result from core_start until core_ack. core_done
// counts only while the core is marked busy here; a core is marked busy from the
// cycle after its dispatch decision until the cycle after its collect decision.
module nonce_dispatch_ctrl #(
   parameter int NUM_NONCES = 16,
   parameter int NUM_CORES  = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [15:0]               output_addr,
   output logic                      done,
   output logic [NUM_CORES-1:0]      core_start,
   output logic [31:0]               core_nonce,
   input  logic [NUM_CORES-1:0]      core_done,
   input  logic [NUM_CORES*32-1:0]   core_hash,
   output logic [NUM_CORES-1:0]      core_ack,
   output logic                      mem_clk,
   output logic                      mem_we,
   output logic [15:0]               mem_addr,
   output logic [31:0]               mem_write_data,
   output logic [1:0]                dbg_state
);

   localparam int CNTW = $clog2(NUM_NONCES + 1);
   localparam int PW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [15:0]           base_addr;
   logic [CNTW-1:0]       issue_cnt;
   logic [CNTW-1:0]       written_cnt;
   logic [NUM_CORES-1:0]  busy;
   logic [CNTW-1:0]       tag [NUM_CORES];
   logic [PW-1:0]         rr_ptr;

   logic                  disp_go;
   logic [PW-1:0]         disp_idx;
   logic [NUM_CORES-1:0]  disp_oh;

   logic [NUM_CORES-1:0]  coll_cand;
   logic                  coll_go;
   logic [PW-1:0]         coll_idx;
   logic [NUM_CORES-1:0]  coll_oh;
   logic [31:0]           coll_hash;
   logic [CNTW-1:0]       coll_tag;
   logic [PW-1:0]         lo_all, lo_hi;
   logic                  any_all, any_hi;

   assign mem_clk   = clk;
   assign dbg_state = state;

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (written_cnt == CNTW'(NUM_NONCES)) state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Dispatch: lowest-index idle core (descending scan, last hit wins).
   always_comb begin
      disp_idx = '0;
      disp_go  = 1'b0;
      disp_oh  = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            disp_idx = PW'(i);
            disp_go  = 1'b1;
         end
      end
      if (state != S_RUN || issue_cnt >= CNTW'(NUM_NONCES)) disp_go = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         disp_oh[i] = disp_go && (disp_idx == PW'(i));
      end
   end

   // Collect: round-robin from rr_ptr. The lowest candidate at or above rr_ptr
   // wins; if there is none, wrap to the lowest candidate overall.
   assign coll_cand = core_done & busy;

   always_comb begin
      lo_all    = '0;
      lo_hi     = '0;
      any_all   = 1'b0;
      any_hi    = 1'b0;
      coll_oh   = '0;
      coll_hash = '0;
      coll_tag  = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (coll_cand[i]) begin
            lo_all  = PW'(i);
            any_all = 1'b1;
            if (PW'(i) >= rr_ptr) begin
               lo_hi  = PW'(i);
               any_hi = 1'b1;
            end
         end
      end
      coll_idx = any_hi ? lo_hi : lo_all;
      coll_go  = (state == S_RUN) && any_all;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (coll_go && (coll_idx == PW'(i))) begin
            coll_oh[i] = 1'b1;
            coll_hash  = core_hash[32*i +: 32];
            coll_tag   = tag[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         base_addr      <= '0;
         issue_cnt      <= '0;
         written_cnt    <= '0;
         busy           <= '0;
         rr_ptr         <= '0;
         for (int i = 0; i < NUM_CORES; i++) tag[i] <= '0;
         done           <= 1'b0;
         core_start     <= '0;
         core_nonce     <= '0;
         core_ack       <= '0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
      end else begin
         state      <= state_nxt;
         done       <= (state == S_FIN);
         core_start <= disp_oh;
         core_ack   <= coll_oh;
         mem_we     <= coll_go;
         // Dispatch and collect never target the same core: one picks idle
         // cores, the other busy ones. A core freed here is seen idle next cycle.
         busy       <= (busy & ~coll_oh) | disp_oh;

         if (state == S_IDLE && start) begin
            base_addr   <= output_addr;
            issue_cnt   <= '0;
            written_cnt <= '0;
         end

         if (disp_go) begin
            core_nonce <= 32'(issue_cnt);
            issue_cnt  <= issue_cnt + CNTW'(1);
         end
         for (int i = 0; i < NUM_CORES; i++) begin
            if (disp_oh[i]) tag[i] <= issue_cnt;
         end

         if (coll_go) begin
            mem_addr       <= base_addr + 16'(coll_tag);
            mem_write_data <= coll_hash;
            rr_ptr         <= (coll_idx == PW'(NUM_CORES - 1)) ? '0 : coll_idx + PW'(1);
            written_cnt    <= written_cnt + CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// Bench for nonce_dispatch_ctrl: instance A (4 cores, 16 nonces) and
// instance B (1 core, 4 nonces). Behavioural core models answer launches.
module tb_nonce_dispatch_ctrl;

   localparam int NC  = 4;
   localparam int NN  = 16;
   localparam int NCB = 1;
   localparam int NNB = 4;

   logic clk;
   logic reset_n;

   // Instance A signals
   logic              a_start;
   logic [15:0]       a_output_addr;
   logic              a_done_o;
   logic [NC-1:0]     a_core_start;
   logic [31:0]       a_core_nonce;
   logic [NC-1:0]     a_core_done;
   logic [NC*32-1:0]  a_core_hash;
   logic [NC-1:0]     a_core_ack;
   logic              a_mem_clk;
   logic              a_mem_we;
   logic [15:0]       a_mem_addr;
   logic [31:0]       a_mem_write_data;
   logic [1:0]        a_dbg;

   // Instance B signals
   logic              b_start;
   logic [15:0]       b_output_addr;
   logic              b_done_o;
   logic [NCB-1:0]    b_core_start;
   logic [31:0]       b_core_nonce;
   logic [NCB-1:0]    b_core_done;
   logic [NCB*32-1:0] b_core_hash;
   logic [NCB-1:0]    b_core_ack;
   logic              b_mem_clk;
   logic              b_mem_we;
   logic [15:0]       b_mem_addr;
   logic [31:0]       b_mem_write_data;
   logic [1:0]        b_dbg;

   nonce_dispatch_ctrl #(.NUM_NONCES(NN), .NUM_CORES(NC)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .start(a_start), .output_addr(a_output_addr),
      .done(a_done_o), .core_start(a_core_start), .core_nonce(a_core_nonce),
      .core_done(a_core_done), .core_hash(a_core_hash), .core_ack(a_core_ack),
      .mem_clk(a_mem_clk), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_write_data(a_mem_write_data), .dbg_state(a_dbg)
   );

   nonce_dispatch_ctrl #(.NUM_NONCES(NNB), .NUM_CORES(NCB)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .output_addr(b_output_addr),
      .done(b_done_o), .core_start(b_core_start), .core_nonce(b_core_nonce),
      .core_done(b_core_done), .core_hash(b_core_hash), .core_ack(b_core_ack),
      .mem_clk(b_mem_clk), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_write_data(b_mem_write_data), .dbg_state(b_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout, required test end");
      $fatal(1, "watchdog expired");
   end

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] hash_of(input logic [31:0] n, input logic [15:0] salt);
      logic [31:0] h;
      h = n * 32'h9E37_79B1;
      return h ^ {salt, 16'h5A5A};
   endfunction

   function automatic logic [15:0] addr_of(input logic [15:0] base, input logic [31:0] n);
      logic [15:0] a;
      a = base + n[15:0];
      return a;
   endfunction

   // ---------------- core model + scoreboard, instance A ----------------
   logic [NC-1:0] m_busy, m_ready, rel_req;
   int            m_cnt [NC];
   logic [31:0]   m_nonce [NC];
   int            lat [NC];
   logic          auto_rel;
   logic [15:0]   a_base;
   int            exp_nonce, start_cnt, wr_cnt, done_cnt;
   logic [47:0]   exp_q[$];
   int            ack_idx_q[$];
   int            ack_cyc_q[$];

   always @(negedge clk) begin : model_a
      int hit;
      if (!reset_n) begin
         m_busy      = '0;
         m_ready     = '0;
         a_core_done = '0;
         a_core_hash = '0;
         for (int i = 0; i < NC; i++) begin
            m_cnt[i]   = 0;
            m_nonce[i] = '0;
         end
      end else begin
         if (a_mem_we || (|a_core_ack))
            check("a_ack_with_write", 64'($onehot(a_core_ack)), 64'(a_mem_we));
         if (a_mem_we) begin
            wr_cnt++;
            hit = -1;
            foreach (exp_q[k]) if (hit < 0 && exp_q[k][47:32] == a_mem_addr) hit = k;
            n_checks++;
            if (hit < 0) begin
               n_fail++;
               $display("FAIL a_write_addr: actual %h, required an outstanding nonce address", a_mem_addr);
            end else begin
               check("a_write_data", a_mem_write_data, exp_q[hit][31:0]);
               exp_q.delete(hit);
            end
            for (int j = 0; j < NC; j++)
               if (a_core_ack[j]) check("a_write_addr_of_acked_core", a_mem_addr, addr_of(a_base, m_nonce[j]));
         end
         for (int j = 0; j < NC; j++) begin
            if (a_core_ack[j]) begin
               ack_idx_q.push_back(j);
               ack_cyc_q.push_back(cyc);
            end
         end
         if (a_done_o) begin
            done_cnt++;
            check("a_done_after_all_writes", exp_q.size(), 0);
         end
         for (int i = 0; i < NC; i++) begin
            if (a_core_ack[i]) begin
               check("a_ack_only_on_done", a_core_done[i], 1);
               a_core_done[i] = 1'b0;
               m_busy[i]      = 1'b0;
               m_ready[i]     = 1'b0;
            end
            if (a_core_start[i]) begin
               check("a_start_core_idle", m_busy[i], 0);
               check("a_nonce_order", a_core_nonce, exp_nonce);
               exp_q.push_back({addr_of(a_base, a_core_nonce), hash_of(a_core_nonce, a_base)});
               exp_nonce++;
               start_cnt++;
               m_busy[i]  = 1'b1;
               m_ready[i] = 1'b0;
               m_nonce[i] = a_core_nonce;
               m_cnt[i]   = lat[i];
            end else if (m_busy[i] && !m_ready[i]) begin
               if (m_cnt[i] <= 1) m_ready[i] = 1'b1;
               else m_cnt[i]--;
            end
            if (m_ready[i] && !a_core_done[i] && (auto_rel || rel_req[i])) begin
               a_core_done[i]          = 1'b1;
               a_core_hash[32*i +: 32] = hash_of(m_nonce[i], a_base);
            end
         end
      end
   end

   // ---------------- core model + scoreboard, instance B ----------------
   logic          b_busy, b_model_done, b_spur;
   int            b_cnt;
   logic [31:0]   b_nonce;
   logic [15:0]   b_base;
   int            b_exp_nonce, b_wr_cnt, b_ack_cnt, b_done_cnt;
   logic [47:0]   b_exp_q[$];
   logic [15:0]   b_addr_log[$];

   assign b_core_done = b_model_done | b_spur;

   always @(negedge clk) begin : model_b
      logic [47:0] e;
      if (!reset_n) begin
         b_busy       = 1'b0;
         b_model_done = 1'b0;
         b_cnt        = 0;
         b_nonce      = '0;
         b_core_hash  = '0;
      end else begin
         if (b_mem_we) begin
            b_wr_cnt++;
            b_addr_log.push_back(b_mem_addr);
            check("b_ack_with_write", b_core_ack, 1);
            n_checks++;
            if (b_exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b_write_unexpected: actual write to %h, required no write", b_mem_addr);
            end else begin
               e = b_exp_q.pop_front();
               check("b_write_addr", b_mem_addr, e[47:32]);
               check("b_write_data", b_mem_write_data, e[31:0]);
            end
         end
         if (b_done_o) b_done_cnt++;
         if (b_core_ack[0]) begin
            b_ack_cnt++;
            b_model_done = 1'b0;
            b_busy       = 1'b0;
         end
         if (b_core_start[0]) begin
            check("b_start_core_idle", b_busy, 0);
            check("b_nonce_order", b_core_nonce, b_exp_nonce);
            b_exp_q.push_back({addr_of(b_base, b_core_nonce), hash_of(b_core_nonce, b_base)});
            b_exp_nonce++;
            b_busy  = 1'b1;
            b_cnt   = 3;
            b_nonce = b_core_nonce;
         end else if (b_busy && !b_model_done) begin
            if (b_cnt <= 1) begin
               b_model_done = 1'b1;
               b_core_hash  = hash_of(b_nonce, b_base);
            end else b_cnt--;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
      lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
   endtask

   task automatic start_a(input logic [15:0] base);
      @(posedge clk); #1;
      a_base    = base;
      exp_nonce = 0;
      start_cnt = 0;
      wr_cnt    = 0;
      done_cnt  = 0;
      exp_q.delete();
      a_output_addr = base;
      a_start       = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
   endtask

   task automatic wait_a_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("a_done_within_budget", 64'(done_cnt > 0), 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_writes(input int cnt, input int budget);
      int n = 0;
      while (wr_cnt < cnt && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("a_writes_within_budget", 64'(wr_cnt >= cnt), 1);
   endtask

   task automatic wait_ready(input logic [NC-1:0] mask, input int budget);
      int n = 0;
      while ((m_ready & mask) != mask && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("a_cores_ready", m_ready & mask, mask);
   endtask

   task automatic release_cores(input logic [NC-1:0] mask, input int n_acks);
      int n = 0;
      ack_idx_q.delete();
      ack_cyc_q.delete();
      rel_req = mask;
      @(posedge clk); #1;
      rel_req = '0;
      while (ack_idx_q.size() < n_acks && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("a_acks_seen", ack_idx_q.size(), n_acks);
   endtask

   task automatic check_order(input string name, input int o0, input int o1, input int o2,
                              input int o3, input int n);
      int ord [4];
      ord = '{o0, o1, o2, o3};
      for (int k = 0; k < n; k++) begin
         if (k < ack_idx_q.size()) check(name, ack_idx_q[k], ord[k]);
         if (k > 0 && k < ack_cyc_q.size()) check("a_acks_back_to_back", ack_cyc_q[k] - ack_cyc_q[k-1], 1);
      end
   endtask

   task automatic check_a_job(input int exp_writes, input int exp_starts, input int exp_dones);
      check("a_write_count", wr_cnt, exp_writes);
      check("a_start_count", start_cnt, exp_starts);
      check("a_done_pulses", done_cnt, exp_dones);
      check("a_all_nonces_written", exp_q.size(), 0);
      check("a_state_idle_after_job", a_dbg, 0);
   endtask

   task automatic check_a_quiet(input string name);
      check(name, {a_done_o, a_core_start, a_core_ack, a_mem_we, a_dbg}, 0);
      check({name, "_data"}, {a_core_nonce, a_mem_addr}, 0);
      check({name, "_wdata"}, a_mem_write_data, 0);
   endtask

   // ---------------- table of jobs ----------------
   typedef struct {
      logic [15:0] base;
      int          l0, l1, l2, l3;
      int          exp_writes, exp_starts, exp_dones;
   } vec_t;
   vec_t tbl [4];

   int snap_ack, snap_wr;

   initial begin
      tbl[0] = '{16'h0100, 10, 10, 10, 10, NN, NN, 1};  // uniform latency
      tbl[1] = '{16'h2000,  5, 17,  9, 30, NN, NN, 1};  // staggered latencies
      tbl[2] = '{16'hFFF8,  3,  1,  7,  2, NN, NN, 1};  // address wrap
      tbl[3] = '{16'h0040,  1,  1,  1,  1, NN, NN, 1};  // fastest cores

      reset_n = 1'b0;
      a_start = 1'b0; a_output_addr = '0;
      b_start = 1'b0; b_output_addr = '0;
      auto_rel = 1'b1; rel_req = '0; a_base = '0; b_base = '0; b_spur = 1'b0;
      exp_nonce = 0; start_cnt = 0; wr_cnt = 0; done_cnt = 0;
      b_exp_nonce = 0; b_wr_cnt = 0; b_ack_cnt = 0; b_done_cnt = 0;
      set_lat(10, 10, 10, 10);
      repeat (3) @(posedge clk);
      #1;
      check_a_quiet("a_reset_outputs");
      check("b_reset_outputs", {b_done_o, b_core_start, b_core_ack, b_mem_we, b_dbg, b_mem_addr}, 0);
      reset_n = 1'b1;

      // Round-robin ordering: all cores done together with rr_ptr at 0, then at 2.
      auto_rel = 1'b0;
      set_lat(2, 2, 2, 2);
      start_a(16'h3000);
      wait_ready(4'hF, 40);
      release_cores(4'hF, 4);
      check_order("a_rr_order_from_0", 0, 1, 2, 3, 4);
      wait_ready(4'hF, 40);
      release_cores(4'b0011, 2);
      check_order("a_rr_advance", 0, 1, 0, 0, 2);
      wait_ready(4'hF, 40);
      release_cores(4'hF, 4);
      check_order("a_rr_order_from_2", 2, 3, 0, 1, 4);
      auto_rel = 1'b1;
      wait_a_done(200);
      check_a_job(NN, NN, 1);

      // Table-driven full jobs
      for (int t = 0; t < 4; t++) begin
         set_lat(tbl[t].l0, tbl[t].l1, tbl[t].l2, tbl[t].l3);
         start_a(tbl[t].base);
         wait_a_done(600);
         check_a_job(tbl[t].exp_writes, tbl[t].exp_starts, tbl[t].exp_dones);
      end

      // start during RUN is ignored; the latched base stays in use
      set_lat(4, 6, 8, 3);
      start_a(16'h1234);
      wait_writes(3, 200);
      a_output_addr = 16'h7777;
      a_start       = 1'b1;
      @(posedge clk); #1;
      a_start       = 1'b0;
      wait_a_done(400);
      check_a_job(NN, NN, 1);
      repeat (20) @(posedge clk);
      #1;
      check("a_no_job_from_ignored_start", start_cnt, NN);
      check("a_single_done_after_ignored_start", done_cnt, 1);

      // Reset mid-job: everything clears, no done, then a clean job
      set_lat(10, 10, 10, 10);
      start_a(16'h4000);
      wait_writes(5, 200);
      reset_n = 1'b0;
      #1;
      check_a_quiet("a_midjob_reset_outputs");
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("a_no_done_after_abandon", done_cnt, 0);
      check("a_idle_after_abandon", a_dbg, 0);
      set_lat(3, 5, 7, 9);
      start_a(16'h0500);
      wait_a_done(400);
      check_a_job(NN, NN, 1);

      // Single core, 4 nonces, base wraps past FFFF
      @(posedge clk); #1;
      b_base = 16'hFFFE;
      b_exp_nonce = 0; b_wr_cnt = 0; b_ack_cnt = 0; b_done_cnt = 0;
      b_exp_q.delete();
      b_addr_log.delete();
      b_output_addr = 16'hFFFE;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      for (int n = 0; n < 100 && b_done_cnt == 0; n++) begin
         @(posedge clk); #1;
      end
      check("b_done_within_budget", 64'(b_done_cnt > 0), 1);
      repeat (3) @(posedge clk);
      #1;
      check("b_write_count", b_wr_cnt, NNB);
      check("b_done_pulses", b_done_cnt, 1);
      check("b_all_nonces_written", b_exp_q.size(), 0);
      begin
         logic [15:0] exp_addr [4];
         exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
         for (int k = 0; k < NNB; k++)
            if (k < b_addr_log.size()) check("b_wrap_addr_sequence", b_addr_log[k], exp_addr[k]);
      end

      // Spurious core_done while idle
      snap_ack = b_ack_cnt;
      snap_wr  = b_wr_cnt;
      b_spur   = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      b_spur   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("b_no_ack_on_spurious_done", b_ack_cnt, snap_ack);
      check("b_no_write_on_spurious_done", b_wr_cnt, snap_wr);
      check("b_idle_after_spurious_done", b_dbg, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
